baud_gen_frac: RTL and testbench
================================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter SYS_CLK, default 3125000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning baud rate used to derive the reset-time increment.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning oversample ticks per bit; legal values are powers of two from 2 to 64.
REQ-004 SHALL have parameter ACC_W, default 24, meaning phase-accumulator width in bits; legal values are 8 to 32.
REQ-005 SHALL have port clk_3125, input, width 1, meaning system clock.
REQ-006 SHALL have port reset, input, width 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port i_en, input, width 1, meaning tick generation enable.
REQ-008 SHALL have port i_sync, input, width 1, meaning phase restart, e.g. on RX start-bit edge.
REQ-009 SHALL have port i_cfg_valid, input, width 1, meaning new-increment request.
REQ-010 SHALL have port i_cfg_incr, input, width ACC_W, meaning requested phase increment.
REQ-011 SHALL have port o_cfg_ready, output, width 1, meaning the block can accept a new increment.
REQ-012 SHALL have port o_os_tick, output, width 1, meaning one-cycle oversample strobe.
REQ-013 SHALL have port o_bit_tick, output, width 1, meaning one-cycle bit strobe.
REQ-014 SHALL have port o_os_idx, output, width log2(OVERSAMPLE), meaning oversample index within the current bit.

Function
REQ-015 SHALL hold an ACC_W-bit accumulator acc and an active increment incr; each cycle with i_en=1 and i_sync=0, acc <= acc+incr (mod 2^ACC_W).
REQ-016 SHALL register o_os_tick high for exactly one cycle in the cycle after the cycle whose addition carried out of bit ACC_W-1.
REQ-017 SHALL advance o_os_idx by one (wrapping OVERSAMPLE-1 -> 0) in the same cycle o_os_tick is high.
REQ-018 SHALL assert o_bit_tick only together with the o_os_tick on which o_os_idx wraps from OVERSAMPLE-1 to 0.
REQ-019 SHALL produce no ticks when incr=0; incr values at or above 2^ACC_W-1 are legal and give at most one tick per cycle.
REQ-020 SHALL freeze acc and o_os_idx and hold both ticks low while i_en=0.
REQ-021 SHALL, on i_sync=1, clear acc and o_os_idx to 0 and suppress any tick due in the following cycle; i_sync takes priority over accumulation and is honoured even when i_en=0.
REQ-022 SHALL implement a configuration FSM with states IDLE (o_cfg_ready=1) and PENDING (o_cfg_ready=0).
REQ-023 SHALL, in IDLE with i_cfg_valid=1, capture i_cfg_incr into a pending register and move to PENDING on the next cycle; i_cfg_valid in PENDING is ignored.
REQ-024 SHALL, in PENDING, copy the pending value into incr and return to IDLE in the cycle o_bit_tick is high, or when i_sync=1, or when i_en=0, whichever comes first.
REQ-025 SHALL never change incr in the middle of a bit while enabled and unsynchronised.
REQ-026 SHALL treat simultaneous i_sync=1 and i_cfg_valid=1 in IDLE as a capture followed by application at the next bit tick, sync or disable; the sync itself restarts phase with the old incr.

Reset
REQ-027 SHALL, while reset=0, asynchronously force: acc=0, o_os_idx=0, o_os_tick=0, o_bit_tick=0, FSM=IDLE, o_cfg_ready=1, pending=0, incr=DEF_INCR.
REQ-028 SHALL compute DEF_INCR at elaboration as round(BAUD*OVERSAMPLE*2^ACC_W/SYS_CLK) using 64-bit arithmetic (9895605 for the default parameters).
REQ-029 SHALL discard any pending configuration when reset is asserted in PENDING.

Structure
REQ-030 SHALL place the DEF_INCR calculation function and the IDLE/PENDING state encoding in shared package baud_pkg.
REQ-031 SHALL be a single module with no sub-modules; the estimated size is 150-250 lines.

Verification
Bench parameters: ACC_W=8, OVERSAMPLE=4.
REQ-032 Load incr=128, i_en=1: o_os_tick every 2nd cycle, o_bit_tick every 8th cycle, o_os_idx sequence 1,2,3,0.
REQ-033 Load incr=85: over 768 enabled cycles, exactly 255 o_os_tick pulses and at most one per cycle.
REQ-034 With incr=128, request incr=64 mid-bit: o_cfg_ready falls; the old 2-cycle spacing persists until o_bit_tick; 4-cycle spacing follows; o_cfg_ready then rises.
REQ-035 Assert i_sync at o_os_idx=2: the next cycle shows o_os_idx=0 and no tick; the first following tick arrives 2 cycles later with incr=128.
REQ-036 Hold i_en=0 for 10 cycles mid-bit: no ticks; resuming continues from the frozen acc and o_os_idx.
REQ-037 Assert reset while PENDING: all outputs take their reset values immediately, o_cfg_ready=1, and incr=DEF_INCR after release.

Source files
------------

// File: rtl/baud_gen_frac_pkg.sv
// Shared definitions for the fractional baud generator: config FSM encoding
// and the elaboration-time default phase increment.
package baud_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_t;

    // round(baud * oversample * 2^acc_w / sys_clk), all in 64-bit arithmetic
    function automatic logic [63:0] calc_def_incr(
        input longint unsigned sys_clk,
        input longint unsigned baud,
        input longint unsigned oversample,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = (baud * oversample) << acc_w;
        return (num + sys_clk / 2) / sys_clk;
    endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// Control/strobe bundle for baud_gen_frac; master drives enable/sync/config,
// slave returns config-ready and the tick strobes.
interface baud_gen_frac_if #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned IDX_W = 4
);
    logic             en;
    logic             sync;
    logic             cfg_valid;
    logic [ACC_W-1:0] cfg_incr;
    logic             cfg_ready;
    logic             os_tick;
    logic             bit_tick;
    logic [IDX_W-1:0] os_idx;

    modport master (
        output en, sync, cfg_valid, cfg_incr,
        input  cfg_ready, os_tick, bit_tick, os_idx
    );

    modport slave (
        input  en, sync, cfg_valid, cfg_incr,
        output cfg_ready, os_tick, bit_tick, os_idx
    );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample/bit tick generator: a phase accumulator whose carry
// produces oversample strobes, with increment updates deferred to bit boundaries.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int unsigned SYS_CLK    = 3125000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_W      = 24
) (
    input  logic                          clk_3125,
    input  logic                          reset,
    input  logic                          i_en,
    input  logic                          i_sync,
    input  logic                          i_cfg_valid,
    input  logic [ACC_W-1:0]              i_cfg_incr,
    output logic                          o_cfg_ready,
    output logic                          o_os_tick,
    output logic                          o_bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_os_idx
);

    localparam int unsigned      IDX_W    = $clog2(OVERSAMPLE);
    localparam logic [ACC_W-1:0] DEF_INCR =
        ACC_W'(calc_def_incr(SYS_CLK, BAUD, OVERSAMPLE, ACC_W));

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] incr;
    logic [ACC_W-1:0] pending;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             capture;
    logic             apply;
    cfg_state_t       state;
    cfg_state_t       state_nxt;

    assign sum   = {1'b0, acc} + {1'b0, incr};
    assign carry = sum[ACC_W];

    // Ticks are registered from the carry, so sync/disable clearing them here
    // also suppresses the strobe that would otherwise appear next cycle.
    always_ff @(posedge clk_3125 or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            o_os_idx   <= '0;
            o_os_tick  <= 1'b0;
            o_bit_tick <= 1'b0;
        end else if (i_sync) begin
            acc        <= '0;
            o_os_idx   <= '0;
            o_os_tick  <= 1'b0;
            o_bit_tick <= 1'b0;
        end else if (i_en) begin
            acc        <= sum[ACC_W-1:0];
            o_os_tick  <= carry;
            o_bit_tick <= carry && (&o_os_idx);
            if (carry) begin
                o_os_idx <= o_os_idx + IDX_W'(1);
            end
        end else begin
            o_os_tick  <= 1'b0;
            o_bit_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk_3125 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                if (i_cfg_valid) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (o_bit_tick || i_sync || !i_en) begin
                    state_nxt = IDLE;
                    apply     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_cfg_ready = (state == IDLE);
        capture     = (state == IDLE) && i_cfg_valid;
    end

    always_ff @(posedge clk_3125 or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            incr    <= DEF_INCR;
        end else begin
            if (capture) begin
                pending <= i_cfg_incr;
            end
            if (apply) begin
                incr <= pending;
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac with ACC_W=8, OVERSAMPLE=4.
module tb_baud_gen_frac;
    import baud_pkg::*;

    localparam int unsigned ACC_W = 8;
    localparam int unsigned OS    = 4;
    localparam int unsigned IDX_W = 2;

    logic clk_3125 = 1'b0;
    logic reset;

    baud_gen_frac_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) bus ();

    baud_gen_frac #(
        .SYS_CLK   (3125000),
        .BAUD      (115200),
        .OVERSAMPLE(OS),
        .ACC_W     (ACC_W)
    ) dut (
        .clk_3125   (clk_3125),
        .reset      (reset),
        .i_en       (bus.en),
        .i_sync     (bus.sync),
        .i_cfg_valid(bus.cfg_valid),
        .i_cfg_incr (bus.cfg_incr),
        .o_cfg_ready(bus.cfg_ready),
        .o_os_tick  (bus.os_tick),
        .o_bit_tick (bus.bit_tick),
        .o_os_idx   (bus.os_idx)
    );

    always #5 clk_3125 = ~clk_3125;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_3125);
        #1;
    endtask

    // capture v, then a sync pulse applies it and restarts phase at acc=0, idx=0
    task automatic load(input logic [ACC_W-1:0] v);
        bus.cfg_valid = 1'b1;
        bus.cfg_incr  = v;
        step();
        bus.cfg_valid = 1'b0;
        bus.sync      = 1'b1;
        step();
        bus.sync      = 1'b0;
    endtask

    task automatic wait_tick(input string tag, input logic [IDX_W-1:0] idx);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            step();
            if (bus.os_tick && bus.os_idx == idx) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt_os;
        int cnt_bit;
        bit exp_t;

        reset         = 1'b0;
        bus.en        = 1'b0;
        bus.sync      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_incr  = '0;
        #2;
        check("rst_os_tick", 32'(bus.os_tick), 32'd0);
        check("rst_bit_tick", 32'(bus.bit_tick), 32'd0);
        check("rst_os_idx", 32'(bus.os_idx), 32'd0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        step();
        reset  = 1'b1;
        bus.en = 1'b1;

        // DEF_INCR = round(115200*4*256/3125000) = 38: first carry on the 7th add
        for (int n = 1; n <= 8; n++) begin
            step();
            check($sformatf("def_tick_%0d", n), 32'(bus.os_tick), 32'(n == 7));
        end
        check("def_idx", 32'(bus.os_idx), 32'd1);

        // incr=128: tick every 2nd cycle, bit tick every 8th
        bus.en = 1'b0;
        load(8'd128);
        bus.en = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            check($sformatf("r128_tick_%0d", n), 32'(bus.os_tick), 32'(n % 2 == 0));
            check($sformatf("r128_idx_%0d", n), 32'(bus.os_idx), 32'((n / 2) % 4));
            check($sformatf("r128_bit_%0d", n), 32'(bus.bit_tick), 32'(n % 8 == 0));
        end

        // sync at idx=2
        wait_tick("sync_wait", 2'd2);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("sync_idx", 32'(bus.os_idx), 32'd0);
        check("sync_tick", 32'(bus.os_tick), 32'd0);
        step();
        check("sync_p1_tick", 32'(bus.os_tick), 32'd0);
        step();
        check("sync_p2_tick", 32'(bus.os_tick), 32'd1);
        check("sync_p2_idx", 32'(bus.os_idx), 32'd1);

        // freeze for 10 cycles at idx=1, acc=0
        bus.en = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            check($sformatf("frz_tick_%0d", n), 32'(bus.os_tick), 32'd0);
            check($sformatf("frz_bit_%0d", n), 32'(bus.bit_tick), 32'd0);
            check($sformatf("frz_idx_%0d", n), 32'(bus.os_idx), 32'd1);
        end
        bus.en = 1'b1;
        step();
        check("resume_p1_tick", 32'(bus.os_tick), 32'd0);
        step();
        check("resume_p2_tick", 32'(bus.os_tick), 32'd1);
        check("resume_p2_idx", 32'(bus.os_idx), 32'd2);

        // request incr=64 mid-bit; a second request while pending is ignored
        bus.cfg_valid = 1'b1;
        bus.cfg_incr  = 8'd64;
        step();
        check("cfg_a1_ready", 32'(bus.cfg_ready), 32'd0);
        check("cfg_a1_tick", 32'(bus.os_tick), 32'd0);
        bus.cfg_incr = 8'd255;
        for (int k = 2; k <= 15; k++) begin
            step();
            bus.cfg_valid = 1'b0;
            exp_t = (k == 2) || (k == 4) || (k == 7) || (k == 11) || (k == 15);
            check($sformatf("cfg_tick_%0d", k), 32'(bus.os_tick), 32'(exp_t));
            check($sformatf("cfg_ready_%0d", k), 32'(bus.cfg_ready), 32'(k >= 5));
            check($sformatf("cfg_bit_%0d", k), 32'(bus.bit_tick), 32'(k == 4));
        end
        check("cfg_end_idx", 32'(bus.os_idx), 32'd3);

        // incr=85 over 768 cycles: 65280/256 = 255 ticks, 63 bit ticks
        bus.en = 1'b0;
        load(8'd85);
        bus.en  = 1'b1;
        cnt_os  = 0;
        cnt_bit = 0;
        for (int n = 0; n < 768; n++) begin
            step();
            if (bus.os_tick) cnt_os++;
            if (bus.bit_tick) cnt_bit++;
        end
        check("r85_os_count", 32'(cnt_os), 32'd255);
        check("r85_bit_count", 32'(cnt_bit), 32'd63);
        check("r85_idx", 32'(bus.os_idx), 32'd3);

        // incr=0: no ticks
        bus.en = 1'b0;
        load(8'd0);
        bus.en = 1'b1;
        cnt_os = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (bus.os_tick) cnt_os++;
        end
        check("zero_incr_ticks", 32'(cnt_os), 32'd0);

        // incr=255: tick every cycle from the 2nd add onwards
        bus.en = 1'b0;
        load(8'd255);
        bus.en = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            check($sformatf("max_tick_%0d", n), 32'(bus.os_tick), 32'(n >= 2));
        end

        // reset while PENDING discards the pending 200
        bus.en = 1'b0;
        load(8'd128);
        bus.en = 1'b1;
        step();
        step();
        step();
        bus.cfg_valid = 1'b1;
        bus.cfg_incr  = 8'd200;
        step();
        bus.cfg_valid = 1'b0;
        check("prst_ready", 32'(bus.cfg_ready), 32'd0);
        check("prst_idx", 32'(bus.os_idx), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_os_tick", 32'(bus.os_tick), 32'd0);
        check("arst_bit_tick", 32'(bus.bit_tick), 32'd0);
        check("arst_idx", 32'(bus.os_idx), 32'd0);
        check("arst_ready", 32'(bus.cfg_ready), 32'd1);
        step();
        reset = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            check($sformatf("post_rst_tick_%0d", n), 32'(bus.os_tick), 32'(n == 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
